fll_cfg_sequencer: RTL and testbench

Sequences the FLL configuration port and the clock-select mux of the clock/reset generator; runs on the reference clock so it works before the FLL locks. After reset it writes two boot configuration words, waits for FLL lock (with timeout), then selects the FLL clock. Afterwards it forwards single host register accesses to the FLL 4-phase req/ack port and falls back to the reference clock on lock loss.

---
 rtl/fll_cfg_pkg.sv | 29 ++
 rtl/fll_cfg_hs.sv | 116 +++++++++++
 rtl/fll_cfg_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fll_cfg_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration sequencer.
package fll_cfg_pkg;

  typedef enum logic [2:0] {
    RESET_IDLE,
    BOOT_WR1,
    BOOT_WR2,
    WAIT_LOCK,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_REL,
    HS_DRAIN
  } hs_phase_t;

  localparam logic [1:0] FLL_STATUS = 2'd0;
  localparam logic [1:0] FLL_CFG1   = 2'd1;
  localparam logic [1:0] FLL_CFG2   = 2'd2;
  localparam logic [1:0] FLL_INTEG  = 2'd3;

  localparam int ST_LOCK_SYNC   = 0;
  localparam int ST_BOOT_DONE   = 1;
  localparam int ST_TIMEOUT_ERR = 2;
  localparam int ST_LOCK_LOST   = 3;

endpackage

// File: rtl/fll_cfg_hs.sv
// Four-phase req/ack engine for the FLL config port; one access per start pulse,
// with a per-edge ack timeout that aborts and then drains the ack without limit.
module fll_cfg_hs
  import fll_cfg_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wrn,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic        fll_ack,
  input  logic [31:0] fll_r_data,
  output logic        fll_req,
  output logic        fll_wrn,
  output logic [1:0]  fll_add,
  output logic [31:0] fll_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  hs_phase_t          phase, phase_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               req_n, wrn_n, done_n, err_n;
  logic [1:0]         add_n;
  logic [31:0]        data_n, rdata_n;

  assign busy = (phase != HS_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= HS_IDLE;
      cnt      <= '0;
      fll_req  <= 1'b0;
      fll_wrn  <= 1'b1;
      fll_add  <= '0;
      fll_data <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      fll_req  <= req_n;
      fll_wrn  <= wrn_n;
      fll_add  <= add_n;
      fll_data <= data_n;
      rdata    <= rdata_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  // Address/data/wrn only change on start, so they stay put until the ack falls.
  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    req_n   = fll_req;
    wrn_n   = fll_wrn;
    add_n   = fll_add;
    data_n  = fll_data;
    rdata_n = rdata;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (phase)
      HS_IDLE: begin
        if (start) begin
          phase_n = HS_REQ;
          req_n   = 1'b1;
          wrn_n   = wrn;
          add_n   = addr;
          data_n  = data;
          cnt_n   = '0;
        end
      end
      HS_REQ: begin
        if (fll_ack) begin
          req_n   = 1'b0;
          rdata_n = fll_r_data;
          phase_n = HS_REL;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          req_n   = 1'b0;
          phase_n = HS_DRAIN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HS_REL: begin
        if (!fll_ack) begin
          phase_n = HS_IDLE;
          done_n  = 1'b1;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          phase_n = HS_DRAIN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HS_DRAIN: begin
        if (!fll_ack) begin
          phase_n = HS_IDLE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end
      end
      default: phase_n = HS_IDLE;
    endcase
  end

endmodule

// File: rtl/fll_cfg_sequencer.sv
// Boots the FLL (two config writes, lock wait), drives the clock mux select and
// forwards host register accesses onto the shared FLL config handshake.
module fll_cfg_sequencer
  import fll_cfg_pkg::*;
#(
  parameter logic [31:0] BOOT_CFG1    = 32'h8000_05F5,
  parameter logic [31:0] BOOT_CFG2    = 32'h0000_0147,
  parameter int          LOCK_TIMEOUT = 4096,
  parameter int          ACK_TIMEOUT  = 64,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        boot_en_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [1:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_gnt_o,
  output logic        host_rvalid_o,
  output logic [31:0] host_rdata_o,
  output logic        host_err_o,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  input  logic        fll_lock_i,
  output logic        clk_sel_o,
  output logic [3:0]  status_o
);

  localparam int LC_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  state_t             state, state_n;
  logic [SYNC_STAGES-1:0] lock_ff;
  logic               lock_sync;
  logic [LC_W-1:0]    lock_cnt, lock_cnt_n;
  logic               clk_sel_n;
  logic               boot_done, boot_done_n;
  logic               timeout_err, timeout_err_n;
  logic               lock_lost, lock_lost_n;
  logic               lock_arm, lock_arm_n;
  logic               host_active, host_active_n;
  logic               hs_start, hs_wrn, hs_busy, hs_done, hs_err;
  logic [1:0]         hs_addr;
  logic [31:0]        hs_data, hs_rdata;

  assign lock_sync = lock_ff[SYNC_STAGES-1];

  fll_cfg_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs (
    .clk        (clk_i),
    .rst        (rst_i),
    .start      (hs_start),
    .wrn        (hs_wrn),
    .addr       (hs_addr),
    .data       (hs_data),
    .fll_ack    (fll_ack_i),
    .fll_r_data (fll_r_data_i),
    .fll_req    (fll_req_o),
    .fll_wrn    (fll_wrn_o),
    .fll_add    (fll_add_o),
    .fll_data   (fll_data_o),
    .busy       (hs_busy),
    .done       (hs_done),
    .err        (hs_err),
    .rdata      (hs_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RESET_IDLE;
      lock_ff     <= '0;
      lock_cnt    <= '0;
      clk_sel_o   <= 1'b0;
      boot_done   <= 1'b0;
      timeout_err <= 1'b0;
      lock_lost   <= 1'b0;
      lock_arm    <= 1'b0;
      host_active <= 1'b0;
    end else begin
      state       <= state_n;
      lock_ff     <= {lock_ff[SYNC_STAGES-2:0], fll_lock_i};
      lock_cnt    <= lock_cnt_n;
      clk_sel_o   <= clk_sel_n;
      boot_done   <= boot_done_n;
      timeout_err <= timeout_err_n;
      lock_lost   <= lock_lost_n;
      lock_arm    <= lock_arm_n;
      host_active <= host_active_n;
    end
  end

  always_comb begin
    state_n       = state;
    lock_cnt_n    = lock_cnt;
    clk_sel_n     = clk_sel_o;
    boot_done_n   = boot_done;
    timeout_err_n = timeout_err | hs_err;
    lock_lost_n   = lock_lost;
    lock_arm_n    = lock_arm;
    host_active_n = host_active & ~hs_done;
    hs_start      = 1'b0;
    hs_wrn        = 1'b1;
    hs_addr       = FLL_STATUS;
    hs_data       = '0;
    host_gnt_o    = 1'b0;
    case (state)
      RESET_IDLE: begin
        if (boot_en_i) begin
          hs_start = 1'b1;
          hs_wrn   = 1'b0;
          hs_addr  = FLL_CFG1;
          hs_data  = BOOT_CFG1;
          state_n  = BOOT_WR1;
        end else begin
          state_n = RUN;
        end
      end
      BOOT_WR1: begin
        if (hs_done && hs_err) begin
          boot_done_n = 1'b1;
          state_n     = RUN;
        end else if (hs_done) begin
          hs_start = 1'b1;
          hs_wrn   = 1'b0;
          hs_addr  = FLL_CFG2;
          hs_data  = BOOT_CFG2;
          state_n  = BOOT_WR2;
        end
      end
      BOOT_WR2: begin
        if (hs_done && hs_err) begin
          boot_done_n = 1'b1;
          state_n     = RUN;
        end else if (hs_done) begin
          lock_cnt_n = '0;
          lock_arm_n = 1'b1;
          state_n    = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_sync) begin
          clk_sel_n   = 1'b1;
          boot_done_n = 1'b1;
          state_n     = RUN;
        end else if (lock_cnt == LC_W'(LOCK_TIMEOUT - 1)) begin
          timeout_err_n = 1'b1;
          boot_done_n   = 1'b1;
          state_n       = RUN;
        end else begin
          lock_cnt_n = lock_cnt + LC_W'(1);
        end
      end
      RUN: begin
        if (host_req_i && !hs_busy && !(host_active && !hs_done)) begin
          host_gnt_o    = 1'b1;
          hs_start      = 1'b1;
          hs_wrn        = ~host_we_i;
          hs_addr       = host_addr_i;
          hs_data       = host_wdata_i;
          host_active_n = 1'b1;
        end
        // Once armed by a successful boot, track lock indefinitely in either direction.
        if (clk_sel_o && !lock_sync) begin
          clk_sel_n   = 1'b0;
          lock_lost_n = 1'b1;
        end else if (lock_arm && lock_sync && !clk_sel_o) begin
          clk_sel_n = 1'b1;
        end
      end
      default: state_n = RESET_IDLE;
    endcase
  end

  assign host_rvalid_o = hs_done & host_active;
  assign host_err_o    = host_rvalid_o & hs_err;
  assign host_rdata_o  = (host_rvalid_o && !hs_err) ? hs_rdata : '0;

  always_comb begin
    status_o                 = '0;
    status_o[ST_LOCK_SYNC]   = lock_sync;
    status_o[ST_BOOT_DONE]   = boot_done;
    status_o[ST_TIMEOUT_ERR] = timeout_err;
    status_o[ST_LOCK_LOST]   = lock_lost;
  end

endmodule

// File: tb/tb_fll_cfg_sequencer.sv
// Scoreboard bench: FLL model with fixed ack latency, queued expectations for FLL
// accesses and host completions, plus directed checks on clock select and status.
module tb_fll_cfg_sequencer;

  localparam logic [31:0] CFG1 = 32'h8000_05F5;
  localparam logic [31:0] CFG2 = 32'h0000_0147;
  localparam int SYNC = 2;
  localparam int ACK_LAT = 3;

  logic        clk, rst, boot_en;
  logic        host_req, host_we;
  logic [1:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt_o, host_rvalid_o, host_err_o;
  logic [31:0] host_rdata_o;
  logic        fll_req_o, fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o;
  logic        fll_ack, fll_lock;
  logic [31:0] fll_r_data;
  logic        clk_sel_o;
  logic [3:0]  status_o;

  logic        no_ack;
  logic [31:0] rd_value;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct { logic wrn; logic [1:0] add; logic [31:0] data; } fll_exp_t;
  typedef struct { logic err; logic [31:0] rdata; } host_exp_t;
  fll_exp_t  exp_fll[$];
  host_exp_t exp_host[$];

  fll_cfg_sequencer dut (
    .clk_i(clk), .rst_i(rst), .boot_en_i(boot_en),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o), .fll_add_o(fll_add_o),
    .fll_data_o(fll_data_o), .fll_ack_i(fll_ack), .fll_r_data_i(fll_r_data),
    .fll_lock_i(fll_lock), .clk_sel_o(clk_sel_o), .status_o(status_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_fll(input logic wrn, input logic [1:0] add, input logic [31:0] data);
    fll_exp_t e;
    e.wrn = wrn; e.add = add; e.data = data;
    exp_fll.push_back(e);
  endtask

  task automatic push_host(input logic err, input logic [31:0] rdata);
    host_exp_t e;
    e.err = err; e.rdata = rdata;
    exp_host.push_back(e);
  endtask

  task automatic push_boot();
    push_fll(1'b0, 2'd1, CFG1);
    push_fll(1'b0, 2'd2, CFG2);
  endtask

  // Called between a negedge and the next posedge so no grant edge is missed.
  task automatic host_access(input logic we, input logic [1:0] addr, input logic [31:0] wd);
    int k;
    host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
    #1;
    k = 0;
    while (!host_gnt_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("gnt_seen", host_gnt_o, 1'b1);
    chk("gnt_after_boot_done", status_o[1], 1'b1);
    @(posedge clk);
    #1 host_req = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_fll.size() != 0 || exp_host.size() != 0) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("queues_drained", (k < 600), 1'b1);
    @(negedge clk);
  endtask

  // FLL model: ack ACK_LAT cycles after req is seen, release once req drops.
  initial begin
    logic        cap_wrn;
    logic [1:0]  cap_add;
    logic [31:0] cap_data;
    int          k;
    fll_ack = 1'b0;
    fll_r_data = '0;
    forever begin
      @(negedge clk);
      if (fll_req_o && !fll_ack) begin
        cap_wrn = fll_wrn_o; cap_add = fll_add_o; cap_data = fll_data_o;
        if (no_ack) begin
          k = 0;
          while (fll_req_o && k < 1000) begin @(negedge clk); k++; end
        end else begin
          repeat (ACK_LAT - 1) @(negedge clk);
          fll_r_data = cap_wrn ? rd_value : 32'h0;
          fll_ack = 1'b1;
          k = 0;
          while (fll_req_o && k < 1000) begin @(negedge clk); k++; end
          chk("req_drop_after_ack", fll_req_o, 1'b0);
          chk("hold_add", fll_add_o, cap_add);
          chk("hold_data", fll_data_o, cap_data);
          chk("hold_wrn", fll_wrn_o, cap_wrn);
          fll_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: FLL access issued on each rising req.
  initial begin
    logic req_q;
    fll_exp_t e;
    req_q = 1'b0;
    forever begin
      @(negedge clk);
      if (fll_req_o && !req_q) begin
        if (exp_fll.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_fll_req: add=%h data=%h wrn=%b", fll_add_o, fll_data_o, fll_wrn_o);
        end else begin
          e = exp_fll.pop_front();
          chk("fll_wrn", fll_wrn_o, e.wrn);
          chk("fll_add", fll_add_o, e.add);
          chk("fll_data", fll_data_o, e.data);
        end
      end
      req_q = fll_req_o;
    end
  end

  // Monitor: host completion pulses.
  initial begin
    host_exp_t e;
    forever begin
      @(negedge clk);
      if (host_rvalid_o) begin
        if (exp_host.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rvalid: rdata=%h err=%b", host_rdata_o, host_err_o);
        end else begin
          e = exp_host.pop_front();
          chk("host_rdata", host_rdata_o, e.rdata);
          chk("host_err", host_err_o, e.err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; boot_en = 1'b1; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; fll_lock = 1'b0; no_ack = 1'b0; rd_value = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", fll_req_o, 1'b0);
    chk("rst_wrn", fll_wrn_o, 1'b1);
    chk("rst_clk_sel", clk_sel_o, 1'b0);
    chk("rst_status", status_o, 4'b0000);
    chk("rst_rvalid", host_rvalid_o, 1'b0);
    chk("rst_gnt", host_gnt_o, 1'b0);

    // Boot with a host write pending from the first cycle; lock 100 cycles later.
    push_boot();
    push_fll(1'b0, 2'd3, 32'h1234_5678);
    push_host(1'b0, 32'h0);
    rst = 1'b0;
    fork
      host_access(1'b1, 2'd3, 32'h1234_5678);
      begin
        repeat (100) @(negedge clk);
        fll_lock = 1'b1;
        repeat (SYNC) @(negedge clk);
        chk("clk_sel_before_sync", clk_sel_o, 1'b0);
        @(negedge clk);
        chk("clk_sel_after_sync", clk_sel_o, 1'b1);
      end
    join
    drain();
    chk("status_boot_ok", status_o, 4'b0011);

    // Host read of the status register.
    rd_value = 32'hDEAD_BEEF;
    push_fll(1'b1, 2'd0, 32'h0);
    push_host(1'b0, 32'hDEAD_BEEF);
    host_access(1'b0, 2'd0, 32'h0);
    drain();

    // Ack never comes: req must drop after the ack timeout, error completion.
    no_ack = 1'b1;
    push_fll(1'b1, 2'd2, 32'h0);
    push_host(1'b1, 32'h0);
    host_access(1'b0, 2'd2, 32'h0);
    cnt = 0;
    while (fll_req_o && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("ack_timeout_cycles", cnt, 64);
    drain();
    chk("status_after_ack_to", status_o, 4'b0111);
    no_ack = 1'b0;
    rd_value = 32'hCAFE_0001;
    push_fll(1'b1, 2'd1, 32'h0);
    push_host(1'b0, 32'hCAFE_0001);
    host_access(1'b0, 2'd1, 32'h0);
    drain();

    // Lock never arrives during boot.
    rst = 1'b1;
    fll_lock = 1'b0;
    exp_fll.delete(); exp_host.delete();
    repeat (2) @(negedge clk);
    push_boot();
    rst = 1'b0;
    repeat (4096) @(negedge clk);
    chk("no_boot_done_before_lock_to", status_o[1], 1'b0);
    repeat (40) @(negedge clk);
    chk("status_lock_to", status_o, 4'b0110);
    chk("clk_sel_lock_to", clk_sel_o, 1'b0);
    chk("boot_writes_done", exp_fll.size(), 0);
    fll_lock = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk("late_lock_before_sync", clk_sel_o, 1'b0);
    @(negedge clk);
    chk("late_lock_clk_sel", clk_sel_o, 1'b1);
    chk("status_late_lock", status_o, 4'b0111);

    // Lock loss in RUN and recovery.
    fll_lock = 1'b0;
    repeat (SYNC) @(negedge clk);
    chk("loss_before_sync", clk_sel_o, 1'b1);
    @(negedge clk);
    chk("loss_clk_sel", clk_sel_o, 1'b0);
    chk("status_lock_lost", status_o, 4'b1110);
    fll_lock = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    chk("relock_clk_sel", clk_sel_o, 1'b1);
    chk("status_relock", status_o, 4'b1111);

    // Reset while a request is outstanding.
    no_ack = 1'b1;
    push_fll(1'b1, 2'd1, 32'h0);
    host_access(1'b0, 2'd1, 32'h0);
    repeat (5) @(negedge clk);
    chk("req_high_before_rst", fll_req_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_drops_req", fll_req_o, 1'b0);
    chk("rst_status2", status_o, 4'b0000);
    chk("rst_clk_sel2", clk_sel_o, 1'b0);
    exp_host.delete();
    no_ack = 1'b0;
    push_boot();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("reboot_writes", exp_fll.size(), 0);
    chk("reboot_clk_sel", clk_sel_o, 1'b1);
    chk("reboot_status", status_o, 4'b0011);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
